// File: rtl/cic_decim_filter_if.sv
// Sample/ratio inputs and decimated-word outputs of the CIC decimator.
// The filter takes the slave side; the bitstream source / SPI loader the master side.
interface cic_decim_filter_if #(
    parameter int LOG2_RMAX = 8,
    parameter int OUT_W     = 12
);
    localparam int KW = $clog2(LOG2_RMAX + 1);

    logic             en;
    logic             data_in;
    logic [KW-1:0]    ratio_sel;
    logic [OUT_W-1:0] data_out;
    logic             data_valid;
    logic             sat;

    modport master (
        output en, data_in, ratio_sel,
        input  data_out, data_valid, sat
    );

    modport slave (
        input  en, data_in, ratio_sel,
        output data_out, data_valid, sat
    );
endinterface

// File: rtl/cic_decim_filter.sv
// CIC decimator for a 1-bit sigma-delta stream: ORDER integrators, 2^k decimation,
// ORDER combs, saturating rescale to OUT_W bits, warm-up after reset or ratio change.
module cic_decim_filter #(
    parameter int ORDER     = 2,
    parameter int LOG2_RMAX = 8,
    parameter int OUT_W     = 12
) (
    input  logic              clk,
    input  logic              rst,
    cic_decim_filter_if.slave bus
);
    localparam int KW  = $clog2(LOG2_RMAX + 1);
    localparam int W   = ORDER * LOG2_RMAX + 1;
    localparam int CW  = LOG2_RMAX;
    localparam int WUW = $clog2(ORDER + 1);

    function automatic logic [KW-1:0] clamp_k(input logic [KW-1:0] k);
        if (k == KW'(0)) begin
            return KW'(1);
        end else if (k > KW'(LOG2_RMAX)) begin
            return KW'(LOG2_RMAX);
        end else begin
            return k;
        end
    endfunction

    logic [W-1:0]     integ_q [ORDER];
    logic [W-1:0]     integ_d [ORDER];
    logic [W-1:0]     dly_q   [ORDER];
    logic [W-1:0]     dly_d   [ORDER];
    logic [W-1:0]     comb_s  [ORDER+1];
    logic [CW-1:0]    cnt_q, cnt_d, last_s;
    logic [KW-1:0]    k_act_q, k_act_d, k_clamp_s;
    logic [WUW-1:0]   warm_q, warm_d;
    logic             valid_q, valid_d, sat_q, sat_d;
    logic [OUT_W-1:0] data_q, data_d, scaled_s;
    logic             resync_s, strobe_s, full_s;
    logic [15:0]      m_s;
    logic [W-1:0]     y_s, top_s, ys_s;

    // Next state: integrators, decimation counter, comb chain, warm-up and scaling.
    always_comb begin
        k_clamp_s = clamp_k(bus.ratio_sel);
        resync_s  = (k_clamp_s != k_act_q);
        k_act_d   = k_clamp_s;
        last_s    = CW'(((CW+1)'(1) << k_act_q) - (CW+1)'(1));
        strobe_s  = bus.en && (cnt_q == last_s) && !resync_s;
        integ_d   = integ_q;
        dly_d     = dly_q;
        cnt_d     = cnt_q;
        warm_d    = warm_q;

        if (bus.en) begin
            integ_d[0] = integ_q[0] + W'(bus.data_in);
            for (int j = 1; j < ORDER; j++) begin
                integ_d[j] = integ_q[j] + integ_q[j-1];
            end
        end else begin
            integ_d = integ_q;
        end

        if (resync_s) begin
            cnt_d = CW'(0);
        end else if (bus.en) begin
            cnt_d = (cnt_q == last_s) ? CW'(0) : cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end

        comb_s[0] = integ_d[ORDER-1];
        for (int i = 0; i < ORDER; i++) begin
            comb_s[i+1] = comb_s[i] - dly_q[i];
        end

        if (resync_s) begin
            for (int i = 0; i < ORDER; i++) begin
                dly_d[i] = W'(0);
            end
            warm_d = WUW'(ORDER);
        end else if (strobe_s) begin
            for (int i = 0; i < ORDER; i++) begin
                dly_d[i] = comb_s[i];
            end
            warm_d = (warm_q != WUW'(0)) ? warm_q - WUW'(1) : warm_q;
        end else begin
            dly_d  = dly_q;
            warm_d = warm_q;
        end

        // y never exceeds 2^M, so only the exact full-scale value needs clipping.
        m_s    = 16'(ORDER) * 16'(k_act_q);
        y_s    = comb_s[ORDER];
        top_s  = W'(1) << m_s;
        full_s = (y_s == top_s);
        ys_s   = full_s ? top_s - W'(1) : y_s;
        if (m_s >= 16'(OUT_W)) begin
            scaled_s = OUT_W'(ys_s >> (m_s - 16'(OUT_W)));
        end else begin
            scaled_s = OUT_W'(ys_s) << (16'(OUT_W) - m_s);
        end

        valid_d = strobe_s && (warm_q == WUW'(0));
        if (valid_d) begin
            data_d = scaled_s;
            sat_d  = full_s;
        end else begin
            data_d = data_q;
            sat_d  = sat_q;
        end
    end

    // State registers; the active ratio reloads from the clamped selector on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ORDER; i++) begin
                integ_q[i] <= {W{1'b0}};
                dly_q[i]   <= {W{1'b0}};
            end
            cnt_q   <= CW'(0);
            k_act_q <= k_clamp_s;
            warm_q  <= WUW'(ORDER);
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
            data_q  <= OUT_W'(0);
        end else begin
            integ_q <= integ_d;
            dly_q   <= dly_d;
            cnt_q   <= cnt_d;
            k_act_q <= k_act_d;
            warm_q  <= warm_d;
            valid_q <= valid_d;
            sat_q   <= sat_d;
            data_q  <= data_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.sat        = sat_q;
endmodule
